// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 fetch/execute slice.
package rv32_pkg;

  // Operation class presented to the execute stage.
  typedef enum logic [2:0] {
    ALU_R     = 3'd0,
    ALU_I     = 3'd1,
    ALU_LS    = 3'd2,
    ALU_BR    = 3'd3,
    ALU_LUI   = 3'd4,
    ALU_AUIPC = 3'd5,
    ALU_JAL   = 3'd6,
    ALU_JALR  = 3'd7
  } aluop_e;

  // Arithmetic funct3 encodings.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3 encodings.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Canonical bubble: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/rv32_alu.sv
// Execute stage: ALU, branch resolution and the EX/MEM result register.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_npc,
  input  logic [2:0]  ex_aluop,
  input  logic [2:0]  ex_func3,
  input  logic        ex_func7,
  output logic [31:0] alu_out,
  output logic        branch,
  output logic [31:0] branch_target
);

  aluop_e      op;
  logic [31:0] res_d, res_q;
  logic        br_d, br_q;
  logic [31:0] tgt_d, tgt_q;

  // Integer op selected by funct3; alt (instr[30]) picks SUB and SRA.
  // Immediate forms never subtract, so sub_ok gates the alt bit for ADD.
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic sub_ok,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] a_s, b_s;
    logic [31:0]        r;
    a_s = a;
    b_s = b;
    case (f3)
      F3_ADD:  r = (alt && sub_ok) ? a - b : a + b;
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = {31'd0, a_s < b_s};
      F3_SLTU: r = {31'd0, a < b};
      F3_XOR:  r = a ^ b;
      F3_SR:   r = alt ? $unsigned(a_s >>> b[4:0]) : a >> b[4:0];
      F3_OR:   r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Conditional-branch comparison; undefined encodings are never taken.
  function automatic logic taken(input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] a_s, b_s;
    logic               t;
    a_s = a;
    b_s = b;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = (a_s < b_s);
      F3_BGE:  t = (a_s >= b_s);
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign op = aluop_e'(ex_aluop);

  // Result, taken flag and target for the current operation class.
  always_comb begin
    res_d = 32'd0;
    br_d  = 1'b0;
    tgt_d = ex_npc + 32'd4;
    case (op)
      ALU_R:     res_d = arith(ex_func3, ex_func7, 1'b1, op_a, op_b);
      ALU_I:     res_d = arith(ex_func3, ex_func7, 1'b0, op_a, ex_imm);
      ALU_LS:    res_d = op_a + ex_imm;
      ALU_BR: begin
        res_d = op_a - op_b;
        br_d  = taken(ex_func3, op_a, op_b);
        tgt_d = ex_npc + ex_imm;
      end
      ALU_LUI:   res_d = ex_imm;
      ALU_AUIPC: res_d = ex_npc + ex_imm;
      ALU_JAL: begin
        res_d = ex_npc + 32'd4;
        br_d  = 1'b1;
        tgt_d = ex_npc + ex_imm;
      end
      ALU_JALR: begin
        res_d = ex_npc + 32'd4;
        br_d  = 1'b1;
        tgt_d = (op_a + ex_imm) & ~32'd1;
      end
      default: res_d = 32'd0;
    endcase
  end

  // EX/MEM register, one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= 32'd0;
      br_q  <= 1'b0;
      tgt_q <= 32'd0;
    end else begin
      res_q <= res_d;
      br_q  <= br_d;
      tgt_q <= tgt_d;
    end
  end

  assign alu_out       = res_q;
  assign branch        = br_q;
  assign branch_target = tgt_q;

endmodule

// File: rtl/rv32_fetch.sv
// Fetch unit: program counter plus the IF/ID pipeline register.
module rv32_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        issue_nop,
  input  logic        jmp_en,
  input  logic [31:0] jmp_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // Next-state for PC and IF/ID: a redirect wins over stall; a bubble
  // request only replaces the latched instruction, the PC still advances.
  always_comb begin
    pc_d     = pc_q + 32'd4;
    pc_out_d = pc_q;
    instr_d  = imem_rdata;
    valid_d  = 1'b1;
    if (jmp_en) begin
      pc_d = jmp_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end
    if (jmp_en || issue_nop) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
    end
  end

  // PC and IF/ID registers with synchronous reset to a bubble at address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= 32'd0;
      pc_out_q <= 32'd0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

endmodule

// File: rtl/rv32_regfile.sv
// 32x32 register file, two asynchronous read ports with write bypass.
module rv32_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] mem_q [32];

  // A read of the register being written this cycle sees the new value;
  // x0 is hardwired to zero regardless of storage contents.
  function automatic logic [31:0] rd_port(input logic [4:0] addr);
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'd0;
    end else if (rf_we && (rf_waddr == addr)) begin
      val = rf_wdata;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  // Storage update: cleared by reset, x0 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      mem_q[rf_waddr] <= rf_wdata;
    end
  end

  assign rs1_data = rd_port(rs1_addr);
  assign rs2_data = rd_port(rs2_addr);

endmodule

// File: rtl/rv32_fetch_exec_core.sv
// Top: fetch unit, register file and ALU wired into a fetch/execute slice.
module rv32_fetch_exec_core
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        issue_nop,
  input  logic        jmp_en,
  input  logic [31:0] jmp_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_npc,
  input  logic [2:0]  ex_aluop,
  input  logic [2:0]  ex_func3,
  input  logic        ex_func7,
  output logic [31:0] alu_out,
  output logic        branch,
  output logic [31:0] branch_target
);

  rv32_fetch #(.NOP_INSTR(NOP_INSTR)) u_fetch (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .issue_nop   (issue_nop),
    .jmp_en      (jmp_en),
    .jmp_pc      (jmp_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .instruction (instruction),
    .valid       (valid)
  );

  rv32_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // The ALU operands come straight from the (bypassed) read ports.
  rv32_alu u_alu (
    .clk           (clk),
    .reset         (reset),
    .op_a          (rs1_data),
    .op_b          (rs2_data),
    .ex_imm        (ex_imm),
    .ex_npc        (ex_npc),
    .ex_aluop      (ex_aluop),
    .ex_func3      (ex_func3),
    .ex_func7      (ex_func7),
    .alu_out       (alu_out),
    .branch        (branch),
    .branch_target (branch_target)
  );

endmodule

// File: tb/tb_rv32_fetch_exec_core.sv
// Bench for rv32_fetch_exec_core: directed sequences, an ALU vector table
// and a randomized run against a behavioural model.
module tb_rv32_fetch_exec_core;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, issue_nop, jmp_en;
  logic [31:0] jmp_pc, imem_addr, imem_rdata, pc_out, instruction;
  logic        valid;
  logic [4:0]  rs1_addr, rs2_addr, rf_waddr;
  logic        rf_we;
  logic [31:0] rf_wdata, rs1_data, rs2_data;
  logic [31:0] ex_imm, ex_npc;
  logic [2:0]  ex_aluop, ex_func3;
  logic        ex_func7;
  logic [31:0] alu_out, branch_target;
  logic        branch;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_fetch_exec_core dut (
    .clk(clk), .reset(reset), .stall(stall), .issue_nop(issue_nop),
    .jmp_en(jmp_en), .jmp_pc(jmp_pc), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc_out(pc_out), .instruction(instruction),
    .valid(valid), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .ex_imm(ex_imm), .ex_npc(ex_npc),
    .ex_aluop(ex_aluop), .ex_func3(ex_func3), .ex_func7(ex_func7),
    .alu_out(alu_out), .branch(branch), .branch_target(branch_target)
  );

  typedef struct {
    logic [31:0] a, b, imm, npc;
    logic [2:0]  op, f3;
    logic        f7;
    logic [31:0] exp_alu;
    logic        exp_br;
    logic [31:0] exp_tgt;
  } alu_vec_t;

  alu_vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = a;
    step();
    rf_waddr = 5'd2; rf_wdata = b;
    step();
    rf_we = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
  endtask

  // Behavioural reference for the execute stage, from the ISA rules.
  function automatic logic slt_s(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] sra(input logic [31:0] a, input int s);
    logic [31:0] fill;
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
    return (a >> s) | fill;
  endfunction

  task automatic ref_ex(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] npc,
                        output logic [31:0] res, output logic br, output logic [31:0] tgt);
    logic [31:0] y;
    int sh;
    br  = 1'b0;
    tgt = npc + 4;
    res = 32'd0;
    if (op == 3'd0 || op == 3'd1) begin
      y  = (op == 3'd0) ? b : imm;
      sh = int'(y % 32);
      case (f3)
        3'd0: res = (op == 3'd0 && f7) ? a + (~y + 1) : a + y;
        3'd1: res = a << sh;
        3'd2: res = {31'd0, slt_s(a, y)};
        3'd3: res = {31'd0, a < y};
        3'd4: res = a ^ y;
        3'd5: res = f7 ? sra(a, sh) : a >> sh;
        3'd6: res = a | y;
        default: res = a & y;
      endcase
    end else if (op == 3'd2) res = a + imm;
    else if (op == 3'd3) begin
      res = a - b;
      tgt = npc + imm;
      case (f3)
        3'd0: br = (a == b);
        3'd1: br = (a != b);
        3'd4: br = slt_s(a, b);
        3'd5: br = !slt_s(a, b);
        3'd6: br = (a < b);
        3'd7: br = !(a < b);
        default: br = 1'b0;
      endcase
    end else if (op == 3'd4) res = imm;
    else if (op == 3'd5) res = npc + imm;
    else begin
      res = npc + 4;
      br  = 1'b1;
      tgt = (op == 3'd6) ? npc + imm : {a[31:1] + imm[31:1] + {30'd0, a[0] & imm[0]}, 1'b0};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_regs [32];
    logic [31:0] m_pc, m_pc_out, m_instr, e_r1, e_r2, e_alu, e_tgt;
    logic        m_valid, e_br;

    vecs[0]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 3'd0, 3'b000, 1'b0, 32'd0, 1'b0, 32'h44};
    vecs[1]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 3'd0, 3'b010, 1'b0, 32'd1, 1'b0, 32'h44};
    vecs[2]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 3'd0, 3'b011, 1'b0, 32'd0, 1'b0, 32'h44};
    vecs[3]  = '{32'hFFFF_FFFF, 32'd4, 32'd0, 32'h40, 3'd0, 3'b101, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h44};
    vecs[4]  = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h40, 3'd3, 3'b100, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h38};
    vecs[5]  = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h40, 3'd3, 3'b110, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h38};
    vecs[6]  = '{32'h103, 32'd0, 32'd4, 32'h20, 3'd7, 3'b000, 1'b0, 32'h24, 1'b1, 32'h106};
    vecs[7]  = '{32'd5, 32'd7, 32'd0, 32'h0, 3'd0, 3'b000, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h4};
    vecs[8]  = '{32'd5, 32'd9, 32'd7, 32'h0, 3'd1, 3'b000, 1'b1, 32'd12, 1'b0, 32'h4};
    vecs[9]  = '{32'd0, 32'd0, 32'h1234_5000, 32'h8, 3'd4, 3'b000, 1'b0, 32'h1234_5000, 1'b0, 32'hC};
    vecs[10] = '{32'd0, 32'd0, 32'h2000, 32'h1000, 3'd5, 3'b000, 1'b0, 32'h3000, 1'b0, 32'h1004};
    vecs[11] = '{32'd0, 32'd0, 32'h10, 32'h80, 3'd6, 3'b000, 1'b0, 32'h84, 1'b1, 32'h90};
    vecs[12] = '{32'h100, 32'd0, 32'hFFFF_FFFC, 32'h0, 3'd2, 3'b000, 1'b0, 32'hFC, 1'b0, 32'h4};
    vecs[13] = '{32'd1, 32'h21, 32'd0, 32'h0, 3'd0, 3'b001, 1'b0, 32'd2, 1'b0, 32'h4};

    reset = 1'b1; stall = 1'b0; issue_nop = 1'b0; jmp_en = 1'b0; jmp_pc = '0;
    imem_rdata = 32'h0050_0093; rs1_addr = '0; rs2_addr = '0; rf_we = 1'b0;
    rf_waddr = '0; rf_wdata = '0; ex_imm = '0; ex_npc = '0; ex_aluop = '0;
    ex_func3 = '0; ex_func7 = 1'b0;
    step(); step();
    chk("rst_pc", imem_addr, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr", instruction, NOP);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_br", {31'd0, branch}, 32'd0);
    chk("rst_tgt", branch_target, 32'd0);

    // First fetch after reset release.
    reset = 1'b0;
    step();
    chk("f1_pc_out", pc_out, 32'd0);
    chk("f1_instr", instruction, 32'h0050_0093);
    chk("f1_valid", {31'd0, valid}, 32'd1);
    step();
    chk("f2_pc_out", pc_out, 32'd4);
    chk("f2_imem_addr", imem_addr, 32'd8);

    // Stall holds everything, then a redirect overrides the stall.
    imem_rdata = 32'hAAAA_AAAA; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc_out", pc_out, 32'd4);
      chk("stall_instr", instruction, 32'h0050_0093);
      chk("stall_addr", imem_addr, 32'd8);
    end
    jmp_en = 1'b1; jmp_pc = 32'h100;
    step();
    chk("jmp_addr", imem_addr, 32'h100);
    chk("jmp_instr", instruction, NOP);
    chk("jmp_valid", {31'd0, valid}, 32'd0);
    chk("jmp_pc_out", pc_out, 32'd8);
    jmp_en = 1'b0; stall = 1'b0; imem_rdata = 32'h00A0_0113;
    step();
    chk("post_jmp_pc_out", pc_out, 32'h100);
    chk("post_jmp_instr", instruction, 32'h00A0_0113);
    chk("post_jmp_valid", {31'd0, valid}, 32'd1);
    issue_nop = 1'b1;
    step();
    chk("nop_instr", instruction, NOP);
    chk("nop_valid", {31'd0, valid}, 32'd0);
    chk("nop_pc_out", pc_out, 32'h104);
    chk("nop_addr", imem_addr, 32'h108);
    issue_nop = 1'b0;

    // Register file: bypass and x0.
    rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'hDEAD_BEEF; rs1_addr = 5'd5;
    #1 chk("rf_bypass", rs1_data, 32'hDEAD_BEEF);
    step();
    rf_waddr = 5'd0; rf_wdata = 32'd7; rs1_addr = 5'd0; rs2_addr = 5'd5;
    #1 chk("rf_x0_bypass", rs1_data, 32'd0);
    chk("rf_stored", rs2_data, 32'hDEAD_BEEF);
    step();
    rf_we = 1'b0;
    #1 chk("rf_x0_after", rs1_data, 32'd0);

    // ALU vector table.
    foreach (vecs[k]) begin
      set_ops(vecs[k].a, vecs[k].b);
      ex_imm = vecs[k].imm; ex_npc = vecs[k].npc; ex_aluop = vecs[k].op;
      ex_func3 = vecs[k].f3; ex_func7 = vecs[k].f7;
      step();
      chk($sformatf("vec%0d_alu", k), alu_out, vecs[k].exp_alu);
      chk($sformatf("vec%0d_br", k), {31'd0, branch}, {31'd0, vecs[k].exp_br});
      chk($sformatf("vec%0d_tgt", k), branch_target, vecs[k].exp_tgt);
    end

    // Randomized run from a clean reset against the behavioural model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 0; m_pc_out = 0; m_instr = NOP; m_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall      = ($urandom_range(0, 3) == 0);
      issue_nop  = ($urandom_range(0, 5) == 0);
      jmp_en     = ($urandom_range(0, 7) == 0);
      jmp_pc     = {$urandom_range(0, 32'hFFFF), 2'b00};
      imem_rdata = $urandom;
      rf_we      = $urandom_range(0, 1);
      rf_waddr   = 5'($urandom_range(0, 7));
      rf_wdata   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rs1_addr   = 5'($urandom_range(0, 7));
      rs2_addr   = 5'($urandom_range(0, 7));
      ex_imm     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
      ex_npc     = $urandom;
      ex_aluop   = 3'($urandom_range(0, 7));
      ex_func3   = 3'($urandom_range(0, 7));
      ex_func7   = 1'($urandom_range(0, 1));
      e_r1 = (rs1_addr == 0) ? 32'd0 : (rf_we && rf_waddr == rs1_addr) ? rf_wdata : m_regs[rs1_addr];
      e_r2 = (rs2_addr == 0) ? 32'd0 : (rf_we && rf_waddr == rs2_addr) ? rf_wdata : m_regs[rs2_addr];
      #1;
      chk("rnd_imem_addr", imem_addr, m_pc);
      chk("rnd_rs1", rs1_data, e_r1);
      chk("rnd_rs2", rs2_data, e_r2);
      ref_ex(ex_aluop, ex_func3, ex_func7, e_r1, e_r2, ex_imm, ex_npc, e_alu, e_br, e_tgt);
      if (jmp_en || issue_nop) begin
        m_pc_out = m_pc; m_instr = NOP; m_valid = 1'b0;
      end else if (!stall) begin
        m_pc_out = m_pc; m_instr = imem_rdata; m_valid = 1'b1;
      end
      if (jmp_en) m_pc = jmp_pc;
      else if (!stall) m_pc = m_pc + 4;
      if (rf_we && rf_waddr != 0) m_regs[rf_waddr] = rf_wdata;
      step();
      chk("rnd_pc_out", pc_out, m_pc_out);
      chk("rnd_instr", instruction, m_instr);
      chk("rnd_valid", {31'd0, valid}, {31'd0, m_valid});
      chk("rnd_alu", alu_out, e_alu);
      chk("rnd_br", {31'd0, branch}, {31'd0, e_br});
      chk("rnd_tgt", branch_target, e_tgt);
    end

    // Reset mid-operation beats stall, redirect and register write.
    set_ops(32'h1111_1111, 32'h2222_2222);
    ex_aluop = 3'd6; ex_npc = 32'h500; ex_imm = 32'h40;
    step();
    chk("pre_rst_br", {31'd0, branch}, 32'd1);
    reset = 1'b1; stall = 1'b1; jmp_en = 1'b1; jmp_pc = 32'h200; issue_nop = 1'b0;
    rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h5555_5555;
    step();
    reset = 1'b0; stall = 1'b0; jmp_en = 1'b0; rf_we = 1'b0;
    rs1_addr = 5'd3; rs2_addr = 5'd1;
    #1;
    chk("mrst_addr", imem_addr, 32'd0);
    chk("mrst_pc_out", pc_out, 32'd0);
    chk("mrst_instr", instruction, NOP);
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_alu", alu_out, 32'd0);
    chk("mrst_br", {31'd0, branch}, 32'd0);
    chk("mrst_tgt", branch_target, 32'd0);
    chk("mrst_x3", rs1_data, 32'd0);
    chk("mrst_x1", rs2_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_exec_core.md
RV32_FETCH_EXEC_CORE -- requirements
Module: rv32_fetch_exec_core

Interface
REQ-001 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and IF/ID outputs.
- issue_nop  in  1  load NOP into the instruction output.
- jmp_en  in  1  redirect fetch.
- jmp_pc  in  32  redirect target.
- imem_addr  out  32  instruction-memory word address (equals PC).
- imem_rdata  in  32  combinational instruction-memory data for imem_addr.
- pc_out  out  32  PC of the instruction on the instruction port.
- instruction  out  32  fetched instruction.
- valid  out  1  pc_out/instruction hold a real fetched instruction.
- rs1_addr, rs2_addr  in  5 each  register read addresses.
- rf_we  in  1  write enable.
- rf_waddr  in  5  write address.
- rf_wdata  in  32  write data.
- rs1_data, rs2_data  out  32 each  read data.
- ex_imm  in  32  sign-extended immediate.
- ex_npc  in  32  PC of the executing instruction.
- ex_aluop  in  3  operation class.
- ex_func3  in  3  RISC-V funct3.
- ex_func7  in  1  instr[30].
- alu_out  out  32  registered result.
- branch  out  1  registered taken flag.
- branch_target  out  32  registered target.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, meaning the instruction word used for bubbles.

Function
REQ-003 Fetch next-PC priority per edge: reset > jmp_en (PC<=jmp_pc) > stall (hold) > PC<=PC+4; imem_addr=PC combinationally.
REQ-004 IF/ID register, same edge and priority: jmp_en or issue_nop -> instruction<=NOP_INSTR, valid<=0, pc_out<=PC; stall -> hold all; else pc_out<=PC, instruction<=imem_rdata, valid<=1.
REQ-005 jmp_en overrides stall; simultaneous jmp_en and issue_nop yields one NOP and a redirect.
REQ-006 Register file 32x32; x0 reads 0 and ignores writes; asynchronous read ports; write on rising edge when rf_we=1.
REQ-007 Same-cycle write/read bypass: if rf_we and rf_waddr==rsN_addr!=0, rsN_data=rf_wdata.
REQ-008 ALU operands A=rs1_data, B=rs2_data internally; results registered one cycle (EX/MEM), latency 1.
REQ-009 ex_aluop: 0 R-type (B operand), 1 I-type (imm operand), 2 load/store (A+imm), 3 branch, 4 LUI (imm), 5 AUIPC (npc+imm), 6 JAL (npc+4), 7 JALR (npc+4).
REQ-010 Arithmetic by func3: 000 ADD/SUB (SUB only R-type with func7=1), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL/SRA (func7), 110 OR, 111 AND; shift amount = operand[4:0]; all 32-bit wraparound.
REQ-011 Branch (aluop 3): func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, others not taken; target=npc+imm; alu_out=A-B.
REQ-012 JAL: branch=1, target=npc+imm; JALR: branch=1, target=(A+imm)&~1; all other classes: branch=0, target=npc+4.

Reset
REQ-013 Reset cycle: PC<=0, pc_out<=0, instruction<=NOP_INSTR, valid<=0, alu_out<=0, branch<=0, branch_target<=0; the first fetch (PC 0) is presented the edge after reset deasserts.
REQ-014 Register-file contents are cleared to 0 by reset.
REQ-015 Reset asserted mid-operation overrides stall, jmp_en and rf_we on that edge.

Structure
REQ-016 Shared package rv32_pkg: ALUop enum (3-bit), funct3 constants, NOP_INSTR value.
REQ-017 Sub-modules: fetch unit, register file, ALU as separate instances under this top (names rv32_fetch, rv32_regfile, rv32_alu).

Verification
REQ-018 Release reset, imem_rdata=32'h00500093 -> next edge pc_out=0, instruction=00500093, valid=1; following edge pc_out=4.
REQ-019 stall=1 for 3 cycles at PC=8 -> pc_out/instruction hold; jmp_en=1, jmp_pc=0x100 during stall -> PC=0x100, instruction=NOP, valid=0.
REQ-020 rf write x5=0xDEADBEEF with rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF (bypass); write x0=7 -> rs1_addr=0 reads 0.
REQ-021 A=0xFFFFFFFF, B=1, aluop0: func3 000 func7 0 -> 0; func3 010 -> 1; func3 011 -> 0; func3 101 func7 1 with B=4 -> 0xFFFFFFFF.
REQ-022 aluop3 func3 100, A=-1, B=0, npc=0x40, imm=-8 -> branch=1, target=0x38; func3 110 same operands -> branch=0.
REQ-023 aluop7 A=0x103, imm=4, npc=0x20 -> alu_out=0x24, branch=1, target=0x106; assert reset -> all registered outputs 0.
